dec_out_reader: RTL and testbench

DEC_OUT_READER -- requirements
Module: dec_out_reader

---
 rtl/dec_out_reader.sv | 153 +++++++++++++++
 tb/tb_dec_out_reader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dec_out_reader.sv
`default_nettype none
// ============================================================================
// Module      : dec_out_reader
// Description : Streams one codeword of decoded bits out of a 1-bit-wide,
//               two-bank RAM. OUT_W consecutive bits are packed LSB-first
//               (lowest address in bit 0) into one word. Each word is then
//               offered on a valid/ready output port.
// Ports       : clk, rst (async, active-high)
//               start, bank_sel       - request; bank sampled with start
//               busy, done            - status; done is a one-cycle pulse
//               ram_cs/we/rs/address  - RAM read port (we is always 0)
//               ram_data_out          - RAM read data, 1-cycle latency
//               m_data/m_valid/m_ready/m_last - packed word stream
// Revision    : 1.0 - initial release
// ============================================================================
module dec_out_reader #(
    parameter int A_WIDTH   = 8,
    parameter int RAM_DEPTH = 1 << A_WIDTH,
    parameter int OUT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               bank_sel,
    output logic               busy,
    output logic               done,
    output logic               ram_cs,
    output logic               ram_we,
    output logic               ram_rs,
    output logic [A_WIDTH-1:0] ram_address,
    input  logic               ram_data_out,
    output logic [OUT_W-1:0]   m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last
);

    localparam int c_NUM_WORDS = RAM_DEPTH / OUT_W;
    localparam int c_CNT_W     = $clog2(OUT_W + 1);
    localparam int c_WORD_W    = (c_NUM_WORDS > 1) ? $clog2(c_NUM_WORDS) : 1;

    // Fill-phase counter: value n-1 at the n-th edge after entering FILL.
    // Below c_LAST_ISSUE another address is issued; from 1 upward a bit
    // is captured; at c_CAPTURE_END the last bit is in and the word is ready.
    localparam logic [c_CNT_W-1:0]  c_LAST_ISSUE  = c_CNT_W'(OUT_W - 1);
    localparam logic [c_CNT_W-1:0]  c_CAPTURE_END = c_CNT_W'(OUT_W);
    localparam logic [c_WORD_W-1:0] c_LAST_WORD   = c_WORD_W'(c_NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_WORD_W-1:0] r_word;
    logic [OUT_W-1:0]    w_shifted;

    // New bit enters at the MSB and moves down, so after OUT_W captures
    // the bit from the lowest address sits in bit 0.
    generate
        if (OUT_W > 1) begin : g_shift_wide
            assign w_shifted = {ram_data_out, m_data[OUT_W-1:1]};
        end else begin : g_shift_one
            assign w_shifted = ram_data_out;
        end
    endgenerate

    assign ram_we = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_word      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_cs      <= 1'b0;
            ram_rs      <= 1'b0;
            ram_address <= '0;
            m_data      <= '0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        ram_rs      <= bank_sel;
                        busy        <= 1'b1;
                        r_word      <= '0;
                        r_cnt       <= '0;
                        ram_address <= '0;
                        ram_cs      <= 1'b1;
                        r_state     <= S_FILL;
                    end
                end

                S_FILL: begin
                    if (r_cnt < c_LAST_ISSUE) begin
                        ram_address <= ram_address + A_WIDTH'(1);
                        ram_cs      <= 1'b1;
                    end else begin
                        // Final address already issued; idle for the read latency.
                        ram_cs <= 1'b0;
                    end
                    // Data for the address issued two edges ago is valid now.
                    if (r_cnt != '0) begin
                        m_data <= w_shifted;
                    end
                    if (r_cnt == c_CAPTURE_END) begin
                        m_valid <= 1'b1;
                        m_last  <= (r_word == c_LAST_WORD);
                        r_state <= S_SEND;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                S_SEND: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        r_word  <= r_word + c_WORD_W'(1);
                        if (r_word == c_LAST_WORD) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            // Addresses are contiguous, so the next word
                            // starts one past the last address issued.
                            ram_address <= ram_address + A_WIDTH'(1);
                            ram_cs      <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= S_FILL;
                        end
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    ram_rs  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dec_out_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec_out_reader
// Description : Directed bench for dec_out_reader with a two-bank 1-bit RAM
//               model and a packing model for the expected words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dec_out_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       bank_sel;
    logic       busy;
    logic       done;
    logic       ram_cs;
    logic       ram_we;
    logic       ram_rs;
    logic [7:0] ram_address;
    logic       ram_data_out = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    logic mem [2][256];

    int total = 0;
    int bad   = 0;

    dec_out_reader #(.A_WIDTH(8), .RAM_DEPTH(256), .OUT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bank_sel     (bank_sel),
        .busy         (busy),
        .done         (done),
        .ram_cs       (ram_cs),
        .ram_we       (ram_we),
        .ram_rs       (ram_rs),
        .ram_address  (ram_address),
        .ram_data_out (ram_data_out),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with one cycle of read latency
    always @(posedge clk) begin
        if (ram_cs) ram_data_out <= mem[ram_rs][ram_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] expw(input bit b, input int w);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = mem[b][w * 8 + k];
        return r;
    endfunction

    function automatic logic [22:0] all_outs();
        return {busy, done, ram_cs, ram_we, ram_rs, ram_address, m_data, m_valid, m_last};
    endfunction

    // Runs one codeword from a start pulse through the cycle after done.
    task automatic stream(input bit bank, input bit toggle_bank, input int stall_word,
                          input bit rnd_ready, input int pulse_word, input int abort_word,
                          input int exp_done_cyc, output bit aborted);
        int cyc, nwords, ndone, done_cyc, first_valid, stall_left;
        bit rs_bad, cs_bad, busy_bad, we_bad, stable_bad, pulsed, holding, ended;
        logic [7:0] hold;
        nwords = 0; ndone = 0; done_cyc = -1; first_valid = -1; stall_left = 5;
        rs_bad = 0; cs_bad = 0; busy_bad = 0; we_bad = 0; stable_bad = 0;
        pulsed = 0; holding = 0; ended = 0; hold = '0; aborted = 0;

        @(negedge clk);
        start = 1'b1; bank_sel = bank; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 2000) begin
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk("busy_after_done", busy, 0);
                chk("done_width", done, 0);
                ended = 1;
                break;
            end
            if (ram_we !== 1'b0) we_bad = 1;
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (busy !== 1'b1) busy_bad = 1;
            if (ram_rs !== bank) rs_bad = 1;
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (abort_word >= 0 && nwords == abort_word && ram_cs) begin
                aborted = 1;
                break;
            end
            if (holding) begin
                if (!m_valid || m_data !== hold) stable_bad = 1;
                if (ram_cs) cs_bad = 1;
            end
            if (pulse_word >= 0 && nwords == pulse_word && !pulsed) begin
                start = 1'b1; pulsed = 1;
            end else begin
                start = 1'b0;
            end
            if (toggle_bank) bank_sel = ~bank_sel;
            if (m_valid && nwords == stall_word && stall_left > 0) begin
                m_ready = 1'b0; stall_left--;
            end else begin
                m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (m_valid && m_ready) begin
                chk($sformatf("word%0d", nwords), m_data, expw(bank, nwords));
                chk($sformatf("last%0d", nwords), m_last, (nwords == 31));
                nwords++;
                holding = 0;
            end else if (m_valid) begin
                holding = 1; hold = m_data;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; m_ready = 1'b1;
        if (aborted) return;
        chk("finished_in_budget", ended, 1);
        chk("word_count", nwords, 32);
        chk("done_count", ndone, 1);
        chk("first_valid_cycle", first_valid, 10);
        chk("ram_rs_constant", rs_bad, 0);
        chk("busy_held", busy_bad, 0);
        chk("ram_we_low", we_bad, 0);
        chk("stall_stable", stable_bad, 0);
        chk("stall_no_cs", cs_bad, 0);
        if (exp_done_cyc > 0) chk("done_cycle", done_cyc, exp_done_cyc);
    endtask

    initial begin
        bit ab;
        rst = 1'b1; start = 1'b0; bank_sel = 1'b0; m_ready = 1'b1;
        #1;
        chk("reset_outputs_async", all_outs(), 0);
        repeat (2) @(negedge clk);
        chk("reset_outputs_held", all_outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("outputs_after_release", all_outs(), 0);

        // Bank 0 alternating bits: every word 0xAA
        for (int a = 0; a < 256; a++) begin
            mem[0][a] = a[0];
            mem[1][a] = 1'b0;
        end
        chk("pattern_word0", expw(0, 0), 8'hAA);
        stream(0, 0, -1, 0, -1, -1, 321, ab);

        // Bank 1 ones, bank 0 zeros, bank_sel toggling mid-run
        for (int a = 0; a < 256; a++) begin
            mem[0][a] = 1'b0;
            mem[1][a] = 1'b1;
        end
        stream(1, 1, -1, 0, -1, -1, 321, ab);

        // Five-cycle stall on word 3
        for (int a = 0; a < 256; a++) mem[0][a] = a[1] ^ a[4];
        stream(0, 0, 3, 0, -1, -1, 326, ab);

        // Start pulse while busy in word 10 is ignored
        stream(0, 0, -1, 0, 10, -1, 321, ab);

        // Reset during FILL of word 5
        for (int a = 0; a < 256; a++) mem[1][a] = a[0] ^ a[2] ^ a[5];
        stream(1, 0, -1, 0, -1, 5, 0, ab);
        chk("abort_reached", ab, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrun_reset_async", all_outs(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrun_reset_release", all_outs(), 0);
        stream(1, 0, -1, 0, -1, -1, 321, ab);

        // Random contents in both banks, random m_ready
        for (int a = 0; a < 256; a++) begin
            mem[0][a] = 1'($urandom_range(0, 1));
            mem[1][a] = 1'($urandom_range(0, 1));
        end
        stream(0, 0, -1, 1, -1, -1, 0, ab);
        stream(1, 0, -1, 1, -1, -1, 0, ab);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
